and_seq_ctrl: RTL
=================

// Module: and_seq_ctrl
// PURPOSE
//  Sequencer that time-multiplexes one 32-bit AND slice (and_gate_32) over a 1024-bit operand pair.
//  Computes c = a & b in NSLICE cycles instead of 32 parallel slices; area-reduced alternative to the
//  fully parallel 1024-bit AND. Sits between the wide-operand producer and its consumer, with
//  valid/ready on both sides.
// PARAMETERS
//  DATA_W   1024  operand/result width; must be an integer multiple of SLICE_W
//  SLICE_W  32    width of the shared AND slice
//  (derived) NSLICE = DATA_W/SLICE_W (32); IDX_W = clog2(NSLICE) (5)
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst_n      in   1        synchronous active-low reset
//  flush      in   1        synchronous abort; returns block to IDLE
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block can accept operands (high only in IDLE)
//  a          in   DATA_W   operand A
//  b          in   DATA_W   operand B
//  out_valid  out  1        result valid (high only in DONE)
//  out_ready  in   1        consumer accepts result
//  c          out  DATA_W   result a & b; held stable while out_valid
//  busy       out  1        state != IDLE
//  slice_idx  out  IDX_W    slice being computed (debug); 0 outside RUN
//  out_zero   out  1        only with AND_SEQ_ZFLAG_EN: result all-zero
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, idx=0, op regs=0, c=0, out_valid=0, busy=0, out_zero=0.
//  Reset or flush mid-operation discards operation; no partial result is ever presented.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. On in_valid&&!flush: latch a,b into op regs, clear c, idx=0, go RUN.
//   RUN: per edge c[idx*SLICE_W +: SLICE_W] <= a_r slice & b_r slice (via shared slice), idx++.
//        On edge with idx==NSLICE-1: write last slice, idx=0, go DONE.
//   DONE: out_valid=1, c stable. On out_ready: go IDLE. Wait indefinitely without out_ready.
//  Latency: accept edge E0; slices written on edges E1..E_NSLICE; out_valid high from E_NSLICE
//   (32 cycles). Throughput: one op per NSLICE+2 cycles min. No overlap between ops.
//  in_ready is combinational from state only (no path from in_valid); out_valid likewise.
//  Operands are sampled only at accept; changes to a/b afterwards have no effect.
//  flush: in any state forces IDLE, idx=0, out_valid=0 next cycle; c retains value but is invalid.
//   flush && in_valid in IDLE -> flush wins, no accept. flush && out_ready in DONE -> IDLE, same result.
//  rst_n has priority over flush.
//  Slice indexing: slice k covers bits [k*SLICE_W+SLICE_W-1 : k*SLICE_W]; slice 0 first.
// CONFIGURATION
//  AND_SEQ_ZFLAG_EN defined: out_zero port exists; internal zacc cleared to 1 at accept,
//   zacc &= ~|slice_result each RUN edge; out_zero=zacc, valid with out_valid; reset value 0.
//  Undefined: out_zero port and zacc logic absent; all other behaviour identical.
// STRUCTURE
//  Package and_seq_pkg: state enum {IDLE,RUN,DONE}, SLICE_W, NSLICE, IDX_W constants.
//  Sub-module: single existing and_gate_32 instance as the shared slice; its inputs are muxed
//   from a_r/b_r by idx. Everything else (FSM, counter, result reg) in this module.
// TESTING
//  1. a=all 1s, b=all 1s, out_ready=1 -> out_valid exactly 32 cycles after accept, c=all 1s.
//  2. a=random, b=random, 20 back-to-back ops -> each c==a&b; in_ready low throughout RUN/DONE.
//  3. Result ready with out_ready=0 for 10 cycles -> out_valid and c held stable; accept after
//     out_ready, in_ready rises next cycle.
//  4. flush asserted at slice_idx=15 -> IDLE next cycle, out_valid never high; next op correct.
//  5. rst_n=0 at slice_idx=7 -> all outputs reset values next cycle; a later op gives c==a&b.
//  6. With AND_SEQ_ZFLAG_EN: a=0x...F0F0, b=0x...0F0F -> out_zero=1; set bit 1023 in both -> 0.

Source files
------------

// File: rtl/and_seq_pkg.sv
// Shared constants and types for the time-multiplexed 1024-bit AND sequencer.
// DATA_W must be an integer multiple of SLICE_W; SLICE_W is fixed at 32 by and_gate_32.
package and_seq_pkg;

  localparam int unsigned DATA_W  = 1024;
  localparam int unsigned SLICE_W = 32;
  localparam int unsigned NSLICE  = DATA_W / SLICE_W;
  localparam int unsigned IDX_W   = $clog2(NSLICE);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/and_seq_if.sv
// Operand/result handshake bundle for and_seq_ctrl.
//  master: producer/consumer side (drives in_valid, a, b, out_ready)
//  slave : sequencer side (drives in_ready, out_valid, c)
interface and_seq_if;
  import and_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] c;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c
  );

endinterface

// File: rtl/and_gate_32.sv
// 32-bit bitwise AND slice, shared by the sequencer across all operand slices.
//  a, b : 32-bit operands
//  y    : a & b
module and_gate_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and_seq_ctrl.sv
// Sequencer computing c = a & b over DATA_W bits using a single 32-bit AND slice,
// one slice per cycle (NSLICE cycles per operation).
// Ports:
//  clk, rst_n (synchronous, active low), flush (synchronous abort to idle)
//  bus       : and_seq_if.slave handshake (in_valid/in_ready/a/b, out_valid/out_ready/c)
//  busy      : state is not idle
//  slice_idx : slice currently being computed, 0 outside RUN
//  out_zero  : result is all-zero; present only when AND_SEQ_ZFLAG_EN is defined
module and_seq_ctrl
  import and_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  and_seq_if.slave         bus,
  output logic             busy,
  output logic [IDX_W-1:0] slice_idx
`ifdef AND_SEQ_ZFLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  a_q, b_q, c_q;
  logic [SLICE_W-1:0] a_slice, b_slice, slice_res;
  logic               load, wr;

  // Shared slice inputs are selected from the latched operands by the slice counter.
  assign a_slice = a_q[idx_q*SLICE_W +: SLICE_W];
  assign b_slice = b_q[idx_q*SLICE_W +: SLICE_W];

  and_gate_32 u_slice (
    .a (a_slice),
    .b (b_slice),
    .y (slice_res)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        wr = 1'b1;
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything in the same cycle; c keeps its partial contents.
    if (flush) begin
      state_d = StIdle;
      idx_d   = '0;
      load    = 1'b0;
      wr      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        a_q <= bus.a;
        b_q <= bus.b;
        c_q <= '0;
      end else if (wr) begin
        c_q[idx_q*SLICE_W +: SLICE_W] <= slice_res;
      end
    end
  end

`ifdef AND_SEQ_ZFLAG_EN
  logic zacc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zacc_q <= 1'b0;
    end else if (load) begin
      zacc_q <= 1'b1;
    end else if (wr) begin
      zacc_q <= zacc_q & ~|slice_res;
    end
  end

  assign out_zero = zacc_q;
`endif

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.c         = c_q;
  assign busy          = (state_q != StIdle);
  assign slice_idx     = idx_q;

endmodule
